// File: rtl/pio_edge_servicer.sv
// ============================================================================
// pio_edge_servicer : Avalon-MM host that services an edge-capture PIO
//                     and streams one event record per service.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module pio_edge_servicer #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] MASK_INIT   = {WIDTH{1'b1}},
    parameter int               POLL_CYCLES = 0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             pio_irq,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH-1:0] ev_edges,
    output logic [WIDTH-1:0] ev_level,
    output logic [CNT_W-1:0] ev_count
);

    localparam logic [2:0] S_INIT        = 3'd0;
    localparam logic [2:0] S_IDLE        = 3'd1;
    localparam logic [2:0] S_RD_EDGE     = 3'd2;
    localparam logic [2:0] S_RD_EDGE_CAP = 3'd3;
    localparam logic [2:0] S_CLR         = 3'd4;
    localparam logic [2:0] S_RD_DATA     = 3'd5;
    localparam logic [2:0] S_RD_DATA_CAP = 3'd6;
    localparam logic [2:0] S_EMIT        = 3'd7;

    logic [2:0]       state_q, state_d;
    logic             init_issued_q;
    logic             poll_tick;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic             cs_q, cs_d;
    logic             wn_q, wn_d;
    logic [1:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             ev_valid_q, ev_valid_d;
    logic [WIDTH-1:0] ev_edges_q, ev_level_q;
    logic [CNT_W-1:0] ev_count_q;
    logic             unused_readdata;

    assign unused_readdata = ^pio_readdata;

    generate
        if (POLL_CYCLES > 0) begin : g_poll
            localparam int               TMR_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
            localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_CYCLES - 1);
            logic [TMR_W-1:0] timer_q, timer_d;

            assign poll_tick = (state_q == S_IDLE) && (timer_q == TMR_LAST);
            assign timer_d   = ((state_q == S_IDLE) && !poll_tick) ? timer_q + 1'b1 : '0;

            always_ff @(posedge clk) begin
                if (!reset_n) timer_q <= '0;
                else          timer_q <= timer_d;
            end
        end else begin : g_no_poll
            assign poll_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    // INIT lasts two cycles: the first (just out of reset) only loads the mask write
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:        if (init_issued_q) state_d = S_IDLE;
            S_IDLE:        if (enable && (pio_irq || poll_tick)) state_d = S_RD_EDGE;
            S_RD_EDGE:     state_d = S_RD_EDGE_CAP;
            S_RD_EDGE_CAP: state_d = (pio_readdata[WIDTH-1:0] == '0) ? S_IDLE : S_CLR;
            S_CLR:         state_d = S_RD_DATA;
            S_RD_DATA:     state_d = S_RD_DATA_CAP;
            S_RD_DATA_CAP: state_d = S_EMIT;
            S_EMIT:        if (ev_ready) state_d = S_IDLE;
            default:       state_d = S_INIT;
        endcase
    end

    assign edge_d = (state_q == S_RD_EDGE_CAP) ? pio_readdata[WIDTH-1:0] : edge_q;

    // Bus outputs are decoded from the next state and registered, so they
    // line up with the state they belong to without any input-to-output path.
    always_comb begin
        cs_d       = 1'b0;
        wn_d       = 1'b1;
        addr_d     = 2'd0;
        wdata_d    = 32'd0;
        ev_valid_d = (state_d == S_EMIT);
        case (state_d)
            S_INIT: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 2'd2;
                wdata_d = 32'(MASK_INIT);
            end
            S_RD_EDGE: begin
                cs_d   = 1'b1;
                addr_d = 2'd3;
            end
            S_RD_EDGE_CAP: addr_d = 2'd3;
            S_CLR: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 2'd3;
                wdata_d = 32'(edge_d);
            end
            S_RD_DATA: cs_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            init_issued_q <= 1'b0;
            edge_q        <= '0;
            cs_q          <= 1'b0;
            wn_q          <= 1'b1;
            addr_q        <= 2'd0;
            wdata_q       <= 32'd0;
            ev_valid_q    <= 1'b0;
            ev_edges_q    <= '0;
            ev_level_q    <= '0;
            ev_count_q    <= '0;
        end else begin
            init_issued_q <= (state_q == S_INIT);
            edge_q        <= edge_d;
            cs_q          <= cs_d;
            wn_q          <= wn_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            ev_valid_q    <= ev_valid_d;
            if (state_q == S_RD_DATA_CAP) begin
                ev_edges_q <= edge_q;
                ev_level_q <= pio_readdata[WIDTH-1:0];
            end
            if (ev_valid_q && ev_ready && (ev_count_q != '1))
                ev_count_q <= ev_count_q + 1'b1;
        end
    end

    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_address    = addr_q;
    assign pio_writedata  = wdata_q;
    assign ev_valid       = ev_valid_q;
    assign ev_edges       = ev_edges_q;
    assign ev_level       = ev_level_q;
    assign ev_count       = ev_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_edge_servicer.sv
// ============================================================================
// tb_pio_edge_servicer : directed scoreboard bench, irq-driven and polled DUTs
// Revision             : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pio_edge_servicer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DUT A: irq driven, default parameters ----------------
    logic        rst_a = 1'b0, en_a = 1'b1, irq_a = 1'b0, evr_a = 1'b1;
    logic [1:0]  addr_a;
    logic        cs_a, wn_a, evv_a;
    logic [31:0] wd_a, rd_a = 32'd0;
    logic [0:0]  eve_a, evl_a;
    logic [15:0] evc_a;
    logic        ecap_a = 1'b0, lvl_a = 1'b1, inj_a = 1'b0;

    pio_edge_servicer dut_a (
        .clk(clk), .reset_n(rst_a), .enable(en_a),
        .pio_address(addr_a), .pio_chipselect(cs_a), .pio_write_n(wn_a),
        .pio_writedata(wd_a), .pio_readdata(rd_a), .pio_irq(irq_a),
        .ev_valid(evv_a), .ev_ready(evr_a), .ev_edges(eve_a),
        .ev_level(evl_a), .ev_count(evc_a)
    );

    // PIO slave model: registered read, clear-on-write edge capture
    always @(posedge clk) begin
        if (cs_a && wn_a)
            rd_a <= (addr_a == 2'd0) ? {31'd0, lvl_a} : (addr_a == 2'd3) ? {31'd0, ecap_a} : 32'd0;
        ecap_a <= (ecap_a & ~(cs_a && !wn_a && addr_a == 2'd3 && wd_a[0])) | inj_a;
    end

    logic [34:0] bus_q[$];
    logic [1:0]  ev_q[$];

    always @(negedge clk) begin
        logic [34:0] e;
        if (cs_a) begin
            if (bus_q.size() == 0) chk("a_bus_unexpected", 64'(bus_q.size()), 64'd1);
            else begin
                e = bus_q.pop_front();
                chk("a_bus", {~wn_a, addr_a, (~wn_a ? wd_a : 32'd0)}, e);
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] r;
        if (evv_a && evr_a) begin
            if (ev_q.size() == 0) chk("a_ev_unexpected", 64'(ev_q.size()), 64'd1);
            else begin
                r = ev_q.pop_front();
                chk("a_ev_record", {eve_a, evl_a}, r);
            end
        end
    end

    // ---------------- DUT B: polled, 2-bit counter ----------------
    logic        rst_b = 1'b0, inj_b = 1'b0, ecap_b = 1'b0, lvl_b = 1'b1;
    logic [1:0]  addr_b;
    logic        cs_b, wn_b, evv_b;
    logic [31:0] wd_b, rd_b = 32'd0;
    logic [0:0]  eve_b, evl_b;
    logic [1:0]  evc_b;

    pio_edge_servicer #(.POLL_CYCLES(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(rst_b), .enable(1'b1),
        .pio_address(addr_b), .pio_chipselect(cs_b), .pio_write_n(wn_b),
        .pio_writedata(wd_b), .pio_readdata(rd_b), .pio_irq(1'b0),
        .ev_valid(evv_b), .ev_ready(1'b1), .ev_edges(eve_b),
        .ev_level(evl_b), .ev_count(evc_b)
    );

    always @(posedge clk) begin
        if (cs_b && wn_b)
            rd_b <= (addr_b == 2'd0) ? {31'd0, lvl_b} : (addr_b == 2'd3) ? {31'd0, ecap_b} : 32'd0;
        ecap_b <= (ecap_b & ~(cs_b && !wn_b && addr_b == 2'd3 && wd_b[0])) | inj_b;
    end

    task automatic push_service(input logic lvl);
        bus_q.push_back({1'b0, 2'd3, 32'd0});
        bus_q.push_back({1'b1, 2'd3, 32'd1});
        bus_q.push_back({1'b0, 2'd0, 32'd0});
        ev_q.push_back({1'b1, lvl});
    endtask

    task automatic inject_a();
        inj_a = 1'b1;
        step();
        inj_a = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        repeat (3) step();
        chk("rst_cs", cs_a, 1'b0);
        chk("rst_write_n", wn_a, 1'b1);
        chk("rst_ev_valid", evv_a, 1'b0);
        chk("rst_ev_edges", eve_a, 1'b0);
        chk("rst_ev_level", evl_a, 1'b0);
        chk("rst_ev_count", evc_a, 16'd0);

        // Mask write after reset release
        bus_q.push_back({1'b1, 2'd2, 32'd1});
        rst_a = 1'b1;
        repeat (3) step();

        // Normal service and latency
        inject_a();
        push_service(1'b1);
        irq_a = 1'b1;
        step();
        irq_a = 1'b0;
        repeat (4) step();
        chk("lat_valid_early", evv_a, 1'b0);
        step();
        chk("lat_valid", evv_a, 1'b1);
        chk("lat_edges", eve_a, 1'b1);
        chk("lat_level", evl_a, 1'b1);
        step();
        chk("accept_valid_low", evv_a, 1'b0);
        chk("count_1", evc_a, 16'd1);

        // Spurious irq: read only
        bus_q.push_back({1'b0, 2'd3, 32'd0});
        irq_a = 1'b1;
        step();
        irq_a = 1'b0;
        repeat (6) step();
        chk("spurious_valid", evv_a, 1'b0);
        chk("spurious_count", evc_a, 16'd1);

        // Back-pressure hold
        lvl_a = 1'b0;
        evr_a = 1'b0;
        inject_a();
        push_service(1'b0);
        irq_a = 1'b1;
        step();
        irq_a = 1'b0;
        repeat (5) step();
        chk("hold_valid_rise", evv_a, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_valid", evv_a, 1'b1);
            chk("hold_edges", eve_a, 1'b1);
            chk("hold_level", evl_a, 1'b0);
        end
        evr_a = 1'b1;
        step();
        chk("hold_accept_valid", evv_a, 1'b0);
        chk("count_2", evc_a, 16'd2);
        step();
        chk("count_2_stable", evc_a, 16'd2);

        // enable low blocks service in IDLE; irq level serviced once enabled
        en_a = 1'b0;
        inject_a();
        irq_a = 1'b1;
        repeat (6) step();
        chk("disabled_valid", evv_a, 1'b0);
        push_service(1'b0);
        en_a = 1'b1;
        step();
        irq_a = 1'b0;
        repeat (6) step();
        chk("enabled_count", evc_a, 16'd3);

        // Reset while in CLR
        inject_a();
        bus_q.push_back({1'b0, 2'd3, 32'd0});
        bus_q.push_back({1'b1, 2'd3, 32'd1});
        irq_a = 1'b1;
        step();
        irq_a = 1'b0;
        step();
        step();
        rst_a = 1'b0;
        step();
        chk("midrst_cs", cs_a, 1'b0);
        chk("midrst_write_n", wn_a, 1'b1);
        chk("midrst_addr", addr_a, 2'd0);
        chk("midrst_valid", evv_a, 1'b0);
        chk("midrst_count", evc_a, 16'd0);
        step();
        bus_q.push_back({1'b1, 2'd2, 32'd1});
        rst_a = 1'b1;
        repeat (4) step();
        chk("midrst_no_event", evv_a, 1'b0);
        chk("a_bus_queue_empty", 64'(bus_q.size()), 64'd0);
        chk("a_ev_queue_empty", 64'(ev_q.size()), 64'd0);

        // Polled DUT: gap, restart and saturating count
        rst_b = 1'b1;
        step();
        chk("b_init_cs", cs_b, 1'b1);
        chk("b_init_wr", {wn_b, addr_b, wd_b}, {1'b0, 2'd2, 32'd1});
        step();
        chk("b_init_done", cs_b, 1'b0);
        for (int i = 0; i < 5; i++) begin
            inj_b = 1'b1;
            n = 0;
            do begin
                step();
                inj_b = 1'b0;
                n++;
            end while (!cs_b && n < 30);
            chk("b_poll_gap", 64'(n), 64'd8);
            chk("b_poll_addr", addr_b, 2'd3);
            m = 0;
            while (!evv_b && m < 30) begin
                step();
                m++;
            end
            chk("b_ev_valid", evv_b, 1'b1);
            chk("b_ev_edges", eve_b, 1'b1);
            chk("b_ev_level", evl_b, 1'b1);
            step();
            chk("b_count", evc_b, (i < 3) ? 2'(i + 1) : 2'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pio_edge_servicer.md
Name: pio_edge_servicer

Overview:
- Avalon-MM host that services an edge-capturing input PIO, such as the button GPI.
- After reset it programs the PIO interrupt mask. It then waits for the PIO irq, or an optional poll tick.
- On service it reads the edge-capture register, clears the captured bits, reads the live input level, and presents one event record on a valid/ready stream to fabric logic.
- It sits between the PIO slave port and a hardware consumer (e.g. LED/menu logic), so no processor is needed to service buttons.

Parameters:
- WIDTH, 1: PIO data width in bits, 1..32.
- MASK_INIT, {WIDTH{1'b1}}: value written to the PIO irq-mask register at init.
- POLL_CYCLES, 0: idle cycles between forced polls; 0 = irq-driven only.
- CNT_W, 16: width of the serviced-event counter.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = service events; 0 = stay in IDLE once init is done.
- pio_address  out  2  Avalon address to PIO (0 data, 2 irq mask, 3 edge capture).
- pio_chipselect  out  1  Avalon chipselect.
- pio_write_n  out  1  Avalon write strobe, active-low.
- pio_writedata  out  32  Avalon write data.
- pio_readdata  in  32  PIO read data; registered in the slave, fixed read latency 1, no waitrequest.
- pio_irq  in  1  PIO level interrupt.
- ev_valid  out  1  event record valid.
- ev_ready  in  1  consumer accepts the record.
- ev_edges  out  WIDTH  edge-capture bits read this service.
- ev_level  out  WIDTH  live PIO input level read after the clear.
- ev_count  out  CNT_W  number of events emitted since reset, saturating.

Behaviour:
Reset (reset_n low at a clk edge):
- State goes to INIT.
- pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
- ev_valid=0, ev_edges=0, ev_level=0, ev_count=0, poll timer=0.
- A reset mid-transaction abandons the transaction; no partial event is emitted.

Bus timing:
- All pio_* outputs come from registered state only; there is no combinational path from any input.

States (one clk each unless noted):
- INIT: chipselect=1, write_n=0, address=2, writedata=MASK_INIT zero-extended. Goes to IDLE.
- IDLE: chipselect=0, write_n=1. Goes to RD_EDGE when enable=1 and (pio_irq=1 or poll tick).
  - Poll tick: only if POLL_CYCLES>0. The timer counts cycles spent in IDLE and fires when it reaches POLL_CYCLES-1. It clears on fire and on leaving IDLE.
- RD_EDGE: chipselect=1, write_n=1, address=3. Goes to RD_EDGE_CAP.
- RD_EDGE_CAP: address held at 3. Samples pio_readdata[WIDTH-1:0] into an edge register.
  - Zero (spurious irq or empty poll): go to IDLE; no clear, no event.
  - Otherwise: go to CLR.
- CLR: chipselect=1, write_n=0, address=3, writedata = captured edges zero-extended. Goes to RD_DATA.
- RD_DATA: chipselect=1, write_n=1, address=0. Goes to RD_DATA_CAP.
- RD_DATA_CAP: samples pio_readdata[WIDTH-1:0] into ev_level and loads ev_edges. Goes to EMIT.
- EMIT: chipselect=0, ev_valid=1. ev_edges and ev_level are stable while ev_valid=1.
  - On ev_valid & ev_ready: ev_count increments, saturating at 2^CNT_W-1. Next state is IDLE and ev_valid=0.
  - The record is held indefinitely while ev_ready=0; new PIO edges accumulate in the PIO during that time.

Latency:
- pio_irq high in IDLE at edge k → ev_valid high after edge k+5.
- With ev_ready tied high, the record is accepted at edge k+6 and the next service can start at edge k+7.

Boundary conditions:
- An edge that lands in the PIO between RD_EDGE_CAP and CLR is lost, because the slave clear has priority. This is an accepted limitation; clearing only the bits that were read bounds the loss for WIDTH>1.
- pio_irq is a level. If it is still high on return to IDLE, the next service starts immediately.
- irq and poll tick in the same cycle → one service.
- enable=0 is honoured only in IDLE; a service in flight completes, including EMIT.

Test Plan:
- Reset release → one write at address 2 with data 0x1 (WIDTH=1), chipselect for exactly 1 cycle, then idle bus. All ev_* are 0 during reset.
- PIO model with edge_capture=1, level=1, pio_irq pulses, ev_ready=1:
  - bus sequence is rd@3, wr@3 data 0x1, rd@0;
  - ev_valid rises 5 clks after irq is sampled, with ev_edges=1, ev_level=1;
  - ev_count becomes 1.
- Spurious case, pio_irq=1 with edge_capture=0 → rd@3 only, no write, ev_valid stays 0, ev_count unchanged.
- ev_ready held 0 for 20 cycles during EMIT → ev_valid and ev_edges stable, no bus activity. One acceptance when ev_ready=1; ev_count +1 only.
- POLL_CYCLES=8, irq tied 0, edge_capture=1 → service starts 8 cycles after entering IDLE. Timer restarts after return to IDLE.
- CNT_W=2, five accepted events → ev_count reads 1, 2, 3, 3, 3.
- reset_n low during CLR → next cycle bus idle, state INIT, ev_valid=0.
